// File: rtl/key_bar_pkg.sv
// Shared types and elaboration helpers for the keyboard-bar raster scanner.
package key_bar_pkg;

  typedef enum logic [2:0] {
    WAIT_FRAME,
    OFFSET,
    BAR,
    GAP,
    DONE
  } bar_state_e;

  // Rows from the start of one bar to the start of the next.
  function automatic int unsigned pitch(input int unsigned bar_h, input int unsigned gap_h);
    return bar_h + gap_h;
  endfunction

  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned x = 1; x < longint'(v); x = x << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/bar_line_tracker.sv
// Line-by-line bar tracker: walks OFFSET/BAR/GAP/DONE on line events, restarts on frame events.
module bar_line_tracker
  import key_bar_pkg::*;
#(
  parameter int unsigned N_BARS   = 15,
  parameter int unsigned BAR_H    = 30,
  parameter int unsigned GAP_H    = 2,
  parameter int unsigned Y_OFFSET = 0,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_evt,
  input  logic             line_evt,
  output logic [IDX_W-1:0] idx_c,
  output logic             valid_c,
  output logic             gap_c,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             gap
);

  localparam logic [CNT_W-1:0] OFS_LAST = CNT_W'(Y_OFFSET - 1);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_H - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_H - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BARS - 1);

  if (BAR_H == 0 || pitch(BAR_H, GAP_H) > (1 << CNT_W)) begin : g_cnt_chk
    $error("BAR_H must be >= 1 and the bar pitch must fit in CNT_W");
  end

  bar_state_e       state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] bar_q, bar_d;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q, gap_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    bar_d   = bar_q;
    if (frame_evt) begin
      row_d   = '0;
      bar_d   = '0;
      state_d = (Y_OFFSET != 0) ? OFFSET : BAR;
    end else if (line_evt) begin
      unique case (state_q)
        OFFSET: begin
          if (row_q == OFS_LAST) begin
            state_d = BAR;
            row_d   = '0;
          end else begin
            row_d = row_q + CNT_W'(1);
          end
        end
        BAR: begin
          if (row_q == BAR_LAST) begin
            row_d = '0;
            if (GAP_H != 0) state_d = GAP;
            else if (bar_q == IDX_LAST) state_d = DONE;
            else bar_d = bar_q + IDX_W'(1);
          end else begin
            row_d = row_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (row_q == GAP_LAST) begin
            row_d = '0;
            if (bar_q == IDX_LAST) state_d = DONE;
            else begin
              state_d = BAR;
              bar_d   = bar_q + IDX_W'(1);
            end
          end else begin
            row_d = row_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
    // Decode of the line being entered, so outputs land one cycle after the event.
    valid_c = (state_d == BAR);
    gap_c   = (state_d == GAP);
    idx_c   = (valid_c || gap_c) ? bar_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_FRAME;
      row_q   <= '0;
      bar_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      bar_q   <= bar_d;
      idx_q   <= idx_c;
      valid_q <= valid_c;
      gap_q   <= gap_c;
    end
  end

  assign idx   = idx_q;
  assign valid = valid_q;
  assign gap   = gap_q;

endmodule

// File: rtl/key_bar_scan.sv
// Keyboard-bar Y scanner: bar tracking plus per-frame key latch, one-hot decode and hit flag.
module key_bar_scan
  import key_bar_pkg::*;
#(
  parameter int unsigned N_BARS   = 15,
  parameter int unsigned BAR_H    = 30,
  parameter int unsigned GAP_H    = 2,
  parameter int unsigned Y_OFFSET = 0,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned CNT_W    = 12
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iFrame_start,
  input  logic              iLine_start,
  input  logic [N_BARS-1:0] iKeys,
  output logic [IDX_W-1:0]  oBar_idx,
  output logic              oBar_valid,
  output logic              oGap,
  output logic [N_BARS-1:0] oBar_onehot,
  output logic              oHit,
  output logic [N_BARS-1:0] oKeys_latched
);

  if (clog2_u(N_BARS) > IDX_W) begin : g_idx_chk
    $error("IDX_W too narrow for N_BARS");
  end

  logic [IDX_W-1:0]  idx_c;
  logic              valid_c, gap_c;
  logic [N_BARS-1:0] keys_q, keys_d;
  logic [N_BARS-1:0] onehot_q, onehot_d;
  logic [N_BARS-1:0] key_shift;
  logic              hit_q, hit_d;

  bar_line_tracker #(
    .N_BARS  (N_BARS),
    .BAR_H   (BAR_H),
    .GAP_H   (GAP_H),
    .Y_OFFSET(Y_OFFSET),
    .IDX_W   (IDX_W),
    .CNT_W   (CNT_W)
  ) u_tracker (
    .clk      (iCLK),
    .rst      (iRST),
    .frame_evt(iFrame_start),
    .line_evt (iLine_start),
    .idx_c    (idx_c),
    .valid_c  (valid_c),
    .gap_c    (gap_c),
    .idx      (oBar_idx),
    .valid    (oBar_valid),
    .gap      (oGap)
  );

  // Hit uses the vector being latched this cycle so line 0 already sees the new frame's keys.
  always_comb begin
    keys_d    = iFrame_start ? iKeys : keys_q;
    onehot_d  = valid_c ? (N_BARS'(1) << idx_c) : '0;
    key_shift = keys_d >> idx_c;
    hit_d     = valid_c && key_shift[0];
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      keys_q   <= '0;
      onehot_q <= '0;
      hit_q    <= 1'b0;
    end else begin
      keys_q   <= keys_d;
      onehot_q <= onehot_d;
      hit_q    <= hit_d;
    end
  end

  assign oBar_onehot   = onehot_q;
  assign oHit          = hit_q;
  assign oKeys_latched = keys_q;

endmodule

// File: tb/tb_key_bar_scan.sv
// Self-checking bench for key_bar_scan: default geometry plus an offset/no-gap variant.
module tb_key_bar_scan;

  typedef struct {
    int idx;
    bit valid;
    bit gap;
    int onehot;
    bit hit;
    int keys;
  } obs_t;

  typedef struct {
    int line;
    int idx;
    bit valid;
    bit gap;
    bit hit;
    int keys;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        fa = 1'b0, la = 1'b0;
  logic [14:0] ka = '0;
  logic [3:0]  a_idx;
  logic        a_valid, a_gap, a_hit;
  logic [14:0] a_onehot, a_keys;

  logic        fb = 1'b0, lb = 1'b0;
  logic [3:0]  kb = '0;
  logic [1:0]  b_idx;
  logic        b_valid, b_gap, b_hit;
  logic [3:0]  b_onehot, b_keys;

  key_bar_scan dut_a (
    .iCLK(clk), .iRST(rst), .iFrame_start(fa), .iLine_start(la), .iKeys(ka),
    .oBar_idx(a_idx), .oBar_valid(a_valid), .oGap(a_gap), .oBar_onehot(a_onehot),
    .oHit(a_hit), .oKeys_latched(a_keys)
  );

  key_bar_scan #(
    .N_BARS(4), .BAR_H(5), .GAP_H(0), .Y_OFFSET(8), .IDX_W(2), .CNT_W(12)
  ) dut_b (
    .iCLK(clk), .iRST(rst), .iFrame_start(fb), .iLine_start(lb), .iKeys(kb),
    .oBar_idx(b_idx), .oBar_valid(b_valid), .oGap(b_gap), .oBar_onehot(b_onehot),
    .oHit(b_hit), .oKeys_latched(b_keys)
  );

  int n_run = 0, n_fail = 0;
  int line_a = -1, line_b = -1;
  int kl_a = 0, kl_b = 0;
  vec_t tab_a[15];
  vec_t tab_b[7];

  // Reference: line number -> bar geometry by division/modulo.
  function automatic obs_t model(input int ln, input int nb, input int bh, input int gh,
                                 input int yo, input int kl);
    obs_t e;
    int r, p, i;
    e = '{default: 0};
    e.keys = kl;
    if (ln < 0 || ln < yo) return e;
    r = ln - yo;
    p = bh + gh;
    i = r / p;
    if (i >= nb) return e;
    e.idx = i;
    if (r % p < bh) begin
      e.valid  = 1'b1;
      e.onehot = 1 << i;
      e.hit    = ((kl >> i) & 1) != 0;
    end else begin
      e.gap = 1'b1;
    end
    return e;
  endfunction

  function automatic obs_t obs_a();
    obs_t o;
    o.idx = int'(a_idx); o.valid = a_valid; o.gap = a_gap;
    o.onehot = int'(a_onehot); o.hit = a_hit; o.keys = int'(a_keys);
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o.idx = int'(b_idx); o.valid = b_valid; o.gap = b_gap;
    o.onehot = int'(b_onehot); o.hit = b_hit; o.keys = int'(b_keys);
    return o;
  endfunction

  task automatic check(input string nm, input obs_t act, input obs_t exp);
    n_run++;
    if (act.idx != exp.idx || act.valid != exp.valid || act.gap != exp.gap ||
        act.onehot != exp.onehot || act.hit != exp.hit || act.keys != exp.keys) begin
      n_fail++;
      $display("FAIL %s: got idx=%0d valid=%0d gap=%0d onehot=%0h hit=%0d keys=%0h; expected idx=%0d valid=%0d gap=%0d onehot=%0h hit=%0d keys=%0h",
               nm, act.idx, act.valid, act.gap, act.onehot, act.hit, act.keys,
               exp.idx, exp.valid, exp.gap, exp.onehot, exp.hit, exp.keys);
    end
  endtask

  task automatic check_vec(input string nm, input vec_t v, input obs_t act);
    obs_t e;
    e.idx = v.idx; e.valid = v.valid; e.gap = v.gap;
    e.onehot = v.valid ? (1 << v.idx) : 0;
    e.hit = v.hit; e.keys = v.keys;
    check(nm, act, e);
  endtask

  task automatic ev_a(input bit f, input bit l, input logic [14:0] k);
    @(negedge clk); fa = f; la = l; ka = k;
    @(negedge clk); fa = 1'b0; la = 1'b0;
    if (f) begin line_a = 0; kl_a = int'(k); end
    else if (l && line_a >= 0) line_a++;
    check($sformatf("a_line%0d", line_a), obs_a(), model(line_a, 15, 30, 2, 0, kl_a));
    foreach (tab_a[t])
      if (tab_a[t].line == line_a && kl_a == 4)
        check_vec($sformatf("a_tab_line%0d", line_a), tab_a[t], obs_a());
  endtask

  task automatic ev_b(input bit f, input bit l, input logic [3:0] k);
    @(negedge clk); fb = f; lb = l; kb = k;
    @(negedge clk); fb = 1'b0; lb = 1'b0;
    if (f) begin line_b = 0; kl_b = int'(k); end
    else if (l && line_b >= 0) line_b++;
    check($sformatf("b_line%0d", line_b), obs_b(), model(line_b, 4, 5, 0, 8, kl_b));
    foreach (tab_b[t])
      if (tab_b[t].line == line_b && kl_b == 10)
        check_vec($sformatf("b_tab_line%0d", line_b), tab_b[t], obs_b());
  endtask

  initial begin
    tab_a[0]  = '{0,   0,  1, 0, 0, 4};
    tab_a[1]  = '{10,  0,  1, 0, 0, 4};
    tab_a[2]  = '{29,  0,  1, 0, 0, 4};
    tab_a[3]  = '{30,  0,  0, 1, 0, 4};
    tab_a[4]  = '{31,  0,  0, 1, 0, 4};
    tab_a[5]  = '{32,  1,  1, 0, 0, 4};
    tab_a[6]  = '{63,  1,  0, 1, 0, 4};
    tab_a[7]  = '{64,  2,  1, 0, 1, 4};
    tab_a[8]  = '{93,  2,  1, 0, 1, 4};
    tab_a[9]  = '{94,  2,  0, 1, 0, 4};
    tab_a[10] = '{477, 14, 1, 0, 0, 4};
    tab_a[11] = '{478, 14, 0, 1, 0, 4};
    tab_a[12] = '{479, 14, 0, 1, 0, 4};
    tab_a[13] = '{480, 0,  0, 0, 0, 4};
    tab_a[14] = '{484, 0,  0, 0, 0, 4};
    tab_b[0]  = '{0,  0, 0, 0, 0, 10};
    tab_b[1]  = '{7,  0, 0, 0, 0, 10};
    tab_b[2]  = '{8,  0, 1, 0, 0, 10};
    tab_b[3]  = '{12, 0, 1, 0, 0, 10};
    tab_b[4]  = '{13, 1, 1, 0, 1, 10};
    tab_b[5]  = '{27, 3, 1, 0, 1, 10};
    tab_b[6]  = '{28, 0, 0, 0, 0, 10};

    // Reset state, then line events with no frame since reset.
    repeat (2) @(negedge clk);
    check("a_reset", obs_a(), model(-1, 15, 30, 2, 0, 0));
    check("b_reset", obs_b(), model(-1, 4, 5, 0, 8, 0));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ev_a(1'b0, 1'b1, 15'h7fff);
      ev_b(1'b0, 1'b1, 4'hf);
    end

    // Full default frame; keys drop to 0 at line 10 but the latch must hold 0x0004.
    ev_a(1'b1, 1'b0, 15'h0004);
    for (int ln = 1; ln <= 484; ln++)
      ev_a(1'b0, 1'b1, (ln >= 10) ? 15'h0000 : 15'h0004);

    // Frame from DONE, then coincident frame+line at line 200.
    ev_a(1'b1, 1'b0, 15'h1234);
    for (int ln = 1; ln <= 200; ln++) ev_a(1'b0, 1'b1, 15'(ln));
    ev_a(1'b1, 1'b1, 15'h0001);
    n_run++;
    if (!(a_idx == 4'd0 && a_valid && !a_gap && a_hit)) begin
      n_fail++;
      $display("FAIL a_coincident: got idx=%0d valid=%0d gap=%0d hit=%0d; expected idx=0 valid=1 gap=0 hit=1",
               a_idx, a_valid, a_gap, a_hit);
    end
    for (int ln = 1; ln <= 35; ln++) ev_a(1'b0, 1'b1, 15'h0000);

    // Async reset mid-frame at line 100 (bar 3 visible).
    ev_a(1'b1, 1'b0, 15'h0008);
    for (int ln = 1; ln <= 100; ln++) ev_a(1'b0, 1'b1, 15'h0000);
    #2 rst = 1'b1;
    line_a = -1; kl_a = 0; line_b = -1; kl_b = 0;
    #1;
    check("a_async_rst", obs_a(), model(-1, 15, 30, 2, 0, 0));
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) ev_a(1'b0, 1'b1, 15'h7fff);
    ev_a(1'b1, 1'b0, 15'h0001);
    ev_a(1'b0, 1'b1, 15'h0000);

    // Offset / no-gap geometry.
    ev_b(1'b1, 1'b0, 4'ha);
    for (int ln = 1; ln <= 31; ln++) ev_b(1'b0, 1'b1, 4'h0);

    // Randomized events on both instances, including idle cycles and early frames.
    for (int i = 0; i < 400; i++) begin
      int c;
      c = int'($urandom_range(0, 99));
      if (c < 3)       ev_a(1'b1, 1'($urandom_range(0, 1)), 15'($urandom));
      else if (c < 80) ev_a(1'b0, 1'b1, 15'($urandom));
      else             ev_a(1'b0, 1'b0, 15'($urandom));
      c = int'($urandom_range(0, 99));
      if (c < 4)       ev_b(1'b1, 1'($urandom_range(0, 1)), 4'($urandom));
      else if (c < 80) ev_b(1'b0, 1'b1, 4'($urandom));
      else             ev_b(1'b0, 1'b0, 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/key_bar_scan.md
Name: key_bar_scan

Overview:
- Parametrised, sequential successor to the combinational keyboard-bar Y-decoder in the DE2_115 synthesizer display path.
- Tracks which horizontal key bar the raster is on, line by line, using a small state machine and counters. No multipliers and no per-bar comparators.
- Flags gap rows between bars.
- Latches the pressed-key vector once per frame, so key highlighting cannot tear mid-frame.
- Sits between the VGA timing generator and the pixel colour mux.

Parameters:
- N_BARS, 15, number of key bars (L5..H5 by default)
- BAR_H, 30, visible rows per bar (BAR_H >= 1)
- GAP_H, 2, separator rows after each bar (0 allowed)
- Y_OFFSET, 0, blank rows before bar 0
- IDX_W, 4, width of bar index; must satisfy 2**IDX_W >= N_BARS
- CNT_W, 12, width of the row counters

Ports:
- iCLK  in  1  pixel clock; all state updates on its rising edge
- iRST  in  1  asynchronous, active-high reset
- iFrame_start  in  1  1-cycle pulse marking the first line of a frame; that line is line 0
- iLine_start  in  1  1-cycle pulse at the start of each line
- iKeys  in  N_BARS  live pressed-key vector, bit i = bar i
- oBar_idx  out  IDX_W  current bar index
- oBar_valid  out  1  current line is a visible row of bar oBar_idx
- oGap  out  1  current line is a gap row following bar oBar_idx
- oBar_onehot  out  N_BARS  one-hot of oBar_idx when oBar_valid, else 0
- oHit  out  1  oBar_valid && latched key[oBar_idx]
- oKeys_latched  out  N_BARS  key vector captured at the last iFrame_start

Behaviour:
Reset:
- Reset is asynchronous and active-high on iRST.
- All outputs reset to 0.
- The state machine resets to WAIT_FRAME.

State machine (advances only on line events):
- WAIT_FRAME: outputs invalid; leaves only on iFrame_start.
- OFFSET: entered on a frame event when Y_OFFSET > 0.
- BAR: entered on a frame event when Y_OFFSET = 0.
- GAP: entered from BAR when GAP_H > 0.
- DONE: reached after the last bar or gap.

Line and frame events:
- A frame event is iFrame_start, with or without iLine_start in the same cycle.
  - It loads line 0: the row counter is cleared and the index is set to 0.
  - It samples iKeys into the latched register in that cycle.
- A line event is iLine_start without iFrame_start.
  - It increments the row counter within the current state.
- If both pulses arrive together, the frame event wins and counts as line 0.

Transitions on line events:
- OFFSET: after Y_OFFSET lines, go to BAR.
- BAR: after BAR_H lines, go to GAP if GAP_H > 0.
  - Otherwise go to BAR with idx+1, or to DONE if idx = N_BARS-1.
- GAP: after GAP_H lines, go to BAR with idx+1, or to DONE if idx = N_BARS-1.
- DONE and WAIT_FRAME: hold until the next frame event.
- iLine_start before any frame event since reset keeps the block in WAIT_FRAME.

Equivalent arithmetic (for the scoreboard):
- Let L be the line number and r = L - Y_OFFSET.
- P = BAR_H + GAP_H, idx = r / P.
- The line is valid iff L >= Y_OFFSET, r % P < BAR_H and idx < N_BARS.
- The line is a gap iff r % P >= BAR_H and idx < N_BARS.

Latency and output rules:
- All outputs are registered.
- They reflect the new line one cycle after the event pulse and stay stable until the next event.
- oBar_idx holds its last value in GAP and is 0 in WAIT_FRAME, OFFSET and DONE.
- oBar_valid and oGap are mutually exclusive.
- oHit and oKeys_latched use only the latched vector. iKeys changes mid-frame have no effect until the next frame event.
- Reset mid-frame: outputs go to 0 immediately; scanning resumes at the next iFrame_start.
- Early frame: a frame event mid-frame or in DONE restarts from line 0 unconditionally.

Decomposition:
- Package key_bar_pkg holds:
  - the state enum: WAIT_FRAME, OFFSET, BAR, GAP, DONE
  - the pitch function P = BAR_H + GAP_H
  - a clog2 helper for checking IDX_W
- One sub-module, bar_line_tracker: the state machine plus row and index counters, producing idx, valid and gap.
- The top level adds the key latch, one-hot decode and hit logic.

Test Plan:
- Defaults; frame at line 0, then line events. Required outputs one cycle after each event:
  - lines 0–29: idx 0, valid
  - lines 30–31: gap, idx 0
  - line 32: idx 1, valid
  - line 477: idx 14, valid
  - lines 478–479: gap, idx 14
  - line 480: DONE, all outputs 0
- iKeys = 15'h0004 at frame start, then changed to 0 at line 10 -> oHit = 1 exactly on lines 64–93 (bar 2), and oKeys_latched = 15'h0004 all frame.
- Y_OFFSET = 8, GAP_H = 0, N_BARS = 4, BAR_H = 5:
  - lines 0–7: invalid
  - line 8: idx 0
  - line 13: idx 1, with no gap
  - line 28: DONE
- iFrame_start and iLine_start pulsed together at line 200 -> next cycle idx 0, valid; counters restart.
- iRST asserted asynchronously at line 100 (bar 3 valid) -> outputs 0 immediately. Line events alone keep WAIT_FRAME; the next iFrame_start resumes at idx 0.
- Line events with no frame since reset -> all outputs stay 0.
